// File: rtl/johnson_phase_decoder_if.sv
// Johnson phase decoder bus: sampled code in, decoded phase and status out.
// master drives the code stream, slave is the decoder.
interface johnson_phase_decoder_if;
  logic        in_valid;
  logic [7:0]  count_in;
  logic [3:0]  phase;
  logic [15:0] phase_onehot;
  logic        phase_valid;
  logic        lock;
  logic        fault;
  logic        illegal_pulse;
  logic        rev_pulse;
  logic [7:0]  rev_count;
  logic [7:0]  err_count;

  modport master (
    output in_valid,
    output count_in,
    input  phase,
    input  phase_onehot,
    input  phase_valid,
    input  lock,
    input  fault,
    input  illegal_pulse,
    input  rev_pulse,
    input  rev_count,
    input  err_count
  );

  modport slave (
    input  in_valid,
    input  count_in,
    output phase,
    output phase_onehot,
    output phase_valid,
    output lock,
    output fault,
    output illegal_pulse,
    output rev_pulse,
    output rev_count,
    output err_count
  );
endinterface

// File: rtl/johnson_phase_decoder.sv
// Decodes an 8-bit Johnson counter into a 0..15 phase and tracks
// lock, faults and completed revolutions of the upstream counter.
module johnson_phase_decoder #(
  parameter int LOCK_N = 3
) (
  input  logic clk,
  input  logic reset,
  johnson_phase_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED,
    FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic [3:0]  prev_q, prev_d;
  logic [3:0]  phase_q, phase_d;
  logic [15:0] onehot_q, onehot_d;
  logic        pv_q, pv_d;
  logic        lock_q, lock_d;
  logic        fault_q, fault_d;
  logic        ill_q, ill_d;
  logic        revp_q, revp_d;
  logic [7:0]  revc_q, revc_d;
  logic [7:0]  errc_q, errc_d;

  logic        legal;
  logic [3:0]  idx;
  logic        step_ok;
  logic        wrap;
  logic        to_fault;
  logic [4:0]  good_inc;

  function automatic logic [7:0] code_of(input logic [3:0] k);
    logic [7:0] c;
    if (k <= 4'd8) c = ~(8'hFF << k);
    else           c = 8'hFF << (k - 4'd8);
    return c;
  endfunction

  always_comb begin
    legal = 1'b0;
    idx   = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (bus.count_in == code_of(4'(k))) begin
        legal = 1'b1;
        idx   = 4'(k);
      end
    end
  end

  assign step_ok  = legal && (idx == prev_q + 4'd1);
  assign wrap     = step_ok && (prev_q == 4'd15);
  assign good_inc = {1'b0, good_q} + 5'd1;

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    prev_d   = prev_q;
    phase_d  = phase_q;
    onehot_d = '0;
    pv_d     = 1'b0;
    ill_d    = 1'b0;
    revp_d   = 1'b0;
    revc_d   = revc_q;
    errc_d   = errc_q;
    to_fault = 1'b0;

    if (bus.in_valid) begin
      if (legal) begin
        phase_d  = idx;
        prev_d   = idx;
        pv_d     = 1'b1;
        onehot_d = 16'h1 << idx;
      end else begin
        ill_d = 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (legal) begin
            state_d = ACQUIRE;
            good_d  = 4'd0;
          end else begin
            to_fault = 1'b1;
          end
        end
        ACQUIRE: begin
          if (!legal) begin
            to_fault = 1'b1;
          end else if (step_ok) begin
            good_d = good_inc[3:0];
            if (good_inc >= 5'(LOCK_N)) state_d = LOCKED;
          end else begin
            good_d = 4'd0;
          end
        end
        LOCKED: begin
          if (step_ok) begin
            if (wrap) begin
              revp_d = 1'b1;
              revc_d = revc_q + 8'd1;
            end
          end else if (legal && idx == 4'd0) begin
            // upstream counter restarted: re-acquire without a fault
            state_d = ACQUIRE;
            good_d  = 4'd0;
          end else begin
            to_fault = 1'b1;
          end
        end
        FAULT: begin
          if (legal && idx == 4'd0) begin
            state_d = ACQUIRE;
            good_d  = 4'd0;
          end
        end
        default: state_d = IDLE;
      endcase

      if (to_fault) begin
        state_d = FAULT;
        if (errc_q != 8'hFF) errc_d = errc_q + 8'd1;
      end
    end

    lock_d  = (state_d == LOCKED);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      good_q   <= '0;
      prev_q   <= '0;
      phase_q  <= '0;
      onehot_q <= '0;
      pv_q     <= 1'b0;
      lock_q   <= 1'b0;
      fault_q  <= 1'b0;
      ill_q    <= 1'b0;
      revp_q   <= 1'b0;
      revc_q   <= '0;
      errc_q   <= '0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      prev_q   <= prev_d;
      phase_q  <= phase_d;
      onehot_q <= onehot_d;
      pv_q     <= pv_d;
      lock_q   <= lock_d;
      fault_q  <= fault_d;
      ill_q    <= ill_d;
      revp_q   <= revp_d;
      revc_q   <= revc_d;
      errc_q   <= errc_d;
    end
  end

  assign bus.phase         = phase_q;
  assign bus.phase_onehot  = onehot_q;
  assign bus.phase_valid   = pv_q;
  assign bus.lock          = lock_q;
  assign bus.fault         = fault_q;
  assign bus.illegal_pulse = ill_q;
  assign bus.rev_pulse     = revp_q;
  assign bus.rev_count     = revc_q;
  assign bus.err_count     = errc_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder: lock, restart, faults,
// input stalls, async reset, revolution wrap and error saturation.
module tb_johnson_phase_decoder;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  logic [7:0] jc [16];

  johnson_phase_decoder_if bus ();

  johnson_phase_decoder #(.LOCK_N(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] c);
    @(negedge clk);
    bus.in_valid = v;
    bus.count_in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".phase"},  16'(bus.phase), 16'h0);
    chk({tag, ".onehot"}, bus.phase_onehot, 16'h0);
    chk({tag, ".pv"},     16'(bus.phase_valid), 16'h0);
    chk({tag, ".lock"},   16'(bus.lock), 16'h0);
    chk({tag, ".fault"},  16'(bus.fault), 16'h0);
    chk({tag, ".ill"},    16'(bus.illegal_pulse), 16'h0);
    chk({tag, ".revp"},   16'(bus.rev_pulse), 16'h0);
    chk({tag, ".revc"},   16'(bus.rev_count), 16'h0);
    chk({tag, ".errc"},   16'(bus.err_count), 16'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    jc = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
           8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.count_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    reset = 1'b1;

    // full sequence 0..15,0: lock after 3 steps, one revolution
    for (int i = 0; i <= 16; i++) begin
      step(1'b1, jc[i % 16]);
      chk("seq.phase",  16'(bus.phase), 16'(i % 16));
      chk("seq.onehot", bus.phase_onehot, 16'h1 << (i % 16));
      chk("seq.pv",     16'(bus.phase_valid), 16'h1);
      chk("seq.lock",   16'(bus.lock), 16'(i >= 3));
      chk("seq.revp",   16'(bus.rev_pulse), 16'(i == 16));
    end
    chk("seq.revc", 16'(bus.rev_count), 16'd1);

    // input stall while locked
    step(1'b1, jc[1]);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h5A);
      chk("stall.phase",  16'(bus.phase), 16'd1);
      chk("stall.pv",     16'(bus.phase_valid), 16'h0);
      chk("stall.onehot", bus.phase_onehot, 16'h0);
      chk("stall.ill",    16'(bus.illegal_pulse), 16'h0);
      chk("stall.lock",   16'(bus.lock), 16'h1);
    end
    step(1'b1, jc[2]);
    chk("resume.phase", 16'(bus.phase), 16'd2);
    chk("resume.lock",  16'(bus.lock), 16'h1);

    // upstream restart at phase 6
    for (int i = 3; i <= 6; i++) step(1'b1, jc[i]);
    chk("p6.lock", 16'(bus.lock), 16'h1);
    step(1'b1, 8'h00);
    chk("restart.lock",  16'(bus.lock), 16'h0);
    chk("restart.fault", 16'(bus.fault), 16'h0);
    chk("restart.errc",  16'(bus.err_count), 16'd0);
    step(1'b1, jc[1]);
    step(1'b1, jc[2]);
    chk("reacq2.lock", 16'(bus.lock), 16'h0);
    step(1'b1, jc[3]);
    chk("reacq3.lock", 16'(bus.lock), 16'h1);

    // illegal code while locked
    step(1'b1, 8'h5A);
    chk("ill.pulse", 16'(bus.illegal_pulse), 16'h1);
    chk("ill.fault", 16'(bus.fault), 16'h1);
    chk("ill.lock",  16'(bus.lock), 16'h0);
    chk("ill.errc",  16'(bus.err_count), 16'd1);
    chk("ill.pv",    16'(bus.phase_valid), 16'h0);
    chk("ill.phase", 16'(bus.phase), 16'd3);
    step(1'b1, 8'h5A);
    chk("ill2.pulse", 16'(bus.illegal_pulse), 16'h1);
    chk("ill2.errc",  16'(bus.err_count), 16'd1);
    step(1'b1, jc[4]);
    chk("flt.stay",  16'(bus.fault), 16'h1);
    chk("flt.ill",   16'(bus.illegal_pulse), 16'h0);
    step(1'b1, 8'h00);
    chk("flt.exit",  16'(bus.fault), 16'h0);
    chk("flt.lock",  16'(bus.lock), 16'h0);

    // skipped phase while locked
    for (int i = 1; i <= 3; i++) step(1'b1, jc[i]);
    chk("skip.pre", 16'(bus.lock), 16'h1);
    step(1'b1, 8'h1F);
    chk("skip.fault", 16'(bus.fault), 16'h1);
    chk("skip.errc",  16'(bus.err_count), 16'd2);
    chk("skip.ill",   16'(bus.illegal_pulse), 16'h0);

    // four more revolutions: rev_count 1 -> 5
    step(1'b1, 8'h00);
    for (int r = 0; r < 4; r++)
      for (int i = 1; i <= 16; i++) step(1'b1, jc[i % 16]);
    chk("rev5.revc", 16'(bus.rev_count), 16'd5);
    chk("rev5.revp", 16'(bus.rev_pulse), 16'h1);

    // async reset between edges
    #2;
    reset = 1'b0;
    #1;
    chk_zero("async");
    @(negedge clk);
    reset = 1'b1;

    // first edge after release samples; lock taken on 15->0 is not a rev
    step(1'b1, 8'h00);
    chk("rel.pv",    16'(bus.phase_valid), 16'h1);
    chk("rel.phase", 16'(bus.phase), 16'd0);
    chk("rel.lock",  16'(bus.lock), 16'h0);
    step(1'b1, jc[13]);
    step(1'b1, jc[14]);
    step(1'b1, jc[15]);
    chk("acqw.lock", 16'(bus.lock), 16'h0);
    step(1'b1, jc[0]);
    chk("acqw.lock1", 16'(bus.lock), 16'h1);
    chk("acqw.revp",  16'(bus.rev_pulse), 16'h0);
    chk("acqw.revc",  16'(bus.rev_count), 16'd0);

    // 256 locked revolutions wrap rev_count
    for (int r = 1; r <= 256; r++) begin
      for (int i = 1; i <= 16; i++) step(1'b1, jc[i % 16]);
      if (r == 255) chk("wrap.255", 16'(bus.rev_count), 16'd255);
    end
    chk("wrap.0",    16'(bus.rev_count), 16'd0);
    chk("wrap.revp", 16'(bus.rev_pulse), 16'h1);

    // err_count saturation
    for (int j = 0; j < 260; j++) begin
      step(1'b1, 8'h5A);
      if (j == 0) chk("sat.first", 16'(bus.err_count), 16'd1);
      step(1'b1, 8'h00);
    end
    chk("sat.255", 16'(bus.err_count), 16'd255);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
